// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU in the E stage, one quotient bit per cycle.
// Optional build macro DIV_EARLY_OUT_EN: finish divide-by-zero and |a|<|b| in the start cycle.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_e,
    input  logic              signed_e,
    input  logic [DATA_W-1:0] a_e,
    input  logic [DATA_W-1:0] b_e,
    input  logic              en_e,
    input  logic              kill_e,
    output logic              div_pending_e,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              result_valid
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } divState_t;

    // Two's complement negation modulo 2^DATA_W when doNeg is set.
    function automatic logic [DATA_W-1:0] condNeg(input logic [DATA_W-1:0] v, input logic doNeg);
        condNeg = doNeg ? ((~v) + ONE) : v;
    endfunction

    divState_t         state;
    divState_t         stateNext;
    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] remReg;
    logic [DATA_W-1:0] quotReg;
    logic [DATA_W-1:0] divisorReg;
    logic              negQ;
    logic              negR;
    logic              pendingRaw;

    logic              startOk;
    logic [DATA_W-1:0] aAbs;
    logic [DATA_W-1:0] bAbs;
    logic [DATA_W:0]   remShift;
    logic              fits;
    logic [DATA_W-1:0] remStep;
    logic [DATA_W-1:0] quotStep;
    logic              lastStep;
    logic              earlyOut;
    logic [DATA_W-1:0] earlyLo;

    assign startOk  = start_e & ~kill_e;
    assign aAbs     = condNeg(a_e, signed_e & a_e[DATA_W-1]);
    assign bAbs     = condNeg(b_e, signed_e & b_e[DATA_W-1]);

    // The partial remainder stays below the divisor, so the low DATA_W bits of the difference are exact.
    assign remShift = {remReg, quotReg[DATA_W-1]};
    assign fits     = (remShift >= {1'b0, divisorReg});
    assign remStep  = fits ? (remShift[DATA_W-1:0] - divisorReg) : remShift[DATA_W-1:0];
    assign quotStep = {quotReg[DATA_W-2:0], fits};
    assign lastStep = (counter == CNT_W'(1));

`ifdef DIV_EARLY_OUT_EN
    assign earlyOut = (b_e == {DATA_W{1'b0}}) | (aAbs < bAbs);
    assign earlyLo  = (b_e == {DATA_W{1'b0}}) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
`else
    assign earlyOut = 1'b0;
    assign earlyLo  = {DATA_W{1'b0}};
`endif

    // Stall request is forced low while reset is held.
    assign div_pending_e = rst & pendingRaw;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and stall-request decode; kill_e wins in every state.
    always_comb begin
        stateNext  = state;
        pendingRaw = 1'b0;
        case (state)
            IDLE: begin
                pendingRaw = startOk;
                if (startOk) begin
                    stateNext = earlyOut ? DONE : BUSY;
                end else begin
                    stateNext = IDLE;
                end
            end
            BUSY: begin
                pendingRaw = 1'b1;
                if (kill_e) begin
                    stateNext = IDLE;
                end else if (lastStep) begin
                    stateNext = DONE;
                end else begin
                    stateNext = BUSY;
                end
            end
            DONE: begin
                if (kill_e || en_e) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = DONE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Operand capture, restoring iteration and sign-corrected result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            counter      <= {CNT_W{1'b0}};
            remReg       <= {DATA_W{1'b0}};
            quotReg      <= {DATA_W{1'b0}};
            divisorReg   <= {DATA_W{1'b0}};
            negQ         <= 1'b0;
            negR         <= 1'b0;
            hi_o         <= {DATA_W{1'b0}};
            lo_o         <= {DATA_W{1'b0}};
            result_valid <= 1'b0;
        end else begin
            result_valid <= (stateNext == DONE);
            case (state)
                IDLE: begin
                    if (startOk) begin
                        remReg     <= {DATA_W{1'b0}};
                        quotReg    <= aAbs;
                        divisorReg <= bAbs;
                        negQ       <= signed_e & (a_e[DATA_W-1] ^ b_e[DATA_W-1]);
                        negR       <= signed_e & a_e[DATA_W-1];
                        counter    <= CNT_W'(DATA_W);
                        if (earlyOut) begin
                            hi_o <= a_e;
                            lo_o <= earlyLo;
                        end
                    end
                end
                BUSY: begin
                    if (!kill_e) begin
                        remReg  <= remStep;
                        quotReg <= quotStep;
                        counter <= counter - CNT_W'(1);
                        if (lastStep) begin
                            lo_o <= condNeg(quotStep, negQ);
                            hi_o <= condNeg(remStep, negR);
                        end
                    end
                end
                default: begin
                    counter <= counter;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, sign rules, kill, DONE hold and reset.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_e;
    logic        signed_e;
    logic [31:0] a_e;
    logic [31:0] b_e;
    logic        en_e;
    logic        kill_e;
    logic        div_pending_e;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        result_valid;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int ZERO_DIV_CYC = 1;
`else
    localparam int ZERO_DIV_CYC = 33;
`endif

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_e      (start_e),
        .signed_e     (signed_e),
        .a_e          (a_e),
        .b_e          (b_e),
        .en_e         (en_e),
        .kill_e       (kill_e),
        .div_pending_e(div_pending_e),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a division, scramble operands afterwards, count pending cycles, check the result.
    task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expLo, input logic [31:0] expHi, input int expCyc);
        int cyc;
        @(negedge clk);
        signed_e = sgn;
        a_e      = a;
        b_e      = b;
        start_e  = 1'b1;
        #1;
        check({tag, "_pend0"}, {31'd0, div_pending_e}, 32'd1);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            start_e  = 1'b0;
            a_e      = $urandom;
            b_e      = $urandom;
            signed_e = ~sgn;
            cyc++;
        end while (div_pending_e === 1'b1 && cyc < 200);
        check({tag, "_cycles"}, 32'(cyc), 32'(expCyc));
        check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
        check({tag, "_lo"}, lo_o, expLo);
        check({tag, "_hi"}, hi_o, expHi);
    endtask

    task automatic releaseDone(input string tag);
        @(negedge clk);
        en_e = 1'b1;
        @(posedge clk);
        #1;
        en_e = 1'b0;
        check({tag, "_rel_valid"}, {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        start_e  = 1'b1;
        signed_e = 1'b0;
        a_e      = 32'd100;
        b_e      = 32'd7;
        en_e     = 1'b0;
        kill_e   = 1'b0;

        // Reset with start_e held high: nothing may leak out.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pend", {31'd0, div_pending_e}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        check("rst_hi", hi_o, 32'd0);
        @(negedge clk);
        start_e = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        check("idle_pend", {31'd0, div_pending_e}, 32'd0);

        runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        releaseDone("divu_100_7");
        runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        releaseDone("div_m7_2");
        runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        releaseDone("div_7_m2");
        runDiv("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        releaseDone("div_min_m1");
        runDiv("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFE, 33);
        releaseDone("div_m8_m3");
        runDiv("divu_big_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 33);
        releaseDone("divu_big_2");
        runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZERO_DIV_CYC);
        releaseDone("divu_5_0");

        // Kill together with start in IDLE blocks the start.
        @(negedge clk);
        signed_e = 1'b0;
        a_e      = 32'd100;
        b_e      = 32'd7;
        start_e  = 1'b1;
        kill_e   = 1'b1;
        #1;
        check("idlekill_pend", {31'd0, div_pending_e}, 32'd0);
        @(posedge clk);
        #1;
        start_e = 1'b0;
        kill_e  = 1'b0;
        check("idlekill_pend2", {31'd0, div_pending_e}, 32'd0);
        check("idlekill_valid", {31'd0, result_valid}, 32'd0);

        // Kill at BUSY cycle 10, then restart two cycles later.
        @(negedge clk);
        start_e = 1'b1;
        @(posedge clk);
        #1;
        start_e = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy10_pend", {31'd0, div_pending_e}, 32'd1);
        @(negedge clk);
        kill_e = 1'b1;
        @(posedge clk);
        #1;
        kill_e = 1'b0;
        check("kill_pend", {31'd0, div_pending_e}, 32'd0);
        check("kill_valid", {31'd0, result_valid}, 32'd0);
        repeat (2) @(posedge clk);
        runDiv("after_kill", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);

        // DONE holds under en_e=0 even with start_e asserted.
        @(negedge clk);
        start_e = 1'b1;
        a_e     = 32'd50;
        b_e     = 32'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_pend", {31'd0, div_pending_e}, 32'd0);
            check("hold_valid", {31'd0, result_valid}, 32'd1);
        end
        check("hold_lo", lo_o, 32'hFFFF_FFFD);
        @(negedge clk);
        start_e = 1'b0;
        en_e    = 1'b1;
        @(posedge clk);
        #1;
        en_e = 1'b0;
        check("hold_rel_valid", {31'd0, result_valid}, 32'd0);
        runDiv("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
        releaseDone("divu_9_3");

        // Reset asserted mid-BUSY clears everything at the next edge.
        runDiv("pre_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        releaseDone("pre_rst");
        @(negedge clk);
        a_e     = 32'd1000;
        b_e     = 32'd3;
        start_e = 1'b1;
        @(posedge clk);
        #1;
        start_e = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_pend", {31'd0, div_pending_e}, 32'd0);
        check("midrst_valid", {31'd0, result_valid}, 32'd0);
        check("midrst_lo", lo_o, 32'd0);
        check("midrst_hi", hi_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_pend", {31'd0, div_pending_e}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
